// File: rtl/sfx_sequencer.sv
// Game-event sound-effect sequencer: turns single-cycle paddle/wall/score events
// into timed note sequences for the downstream square-wave tone generator.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | no effect playing, note=0
// S_PLAY   | current (fx, step) note driven, prescaler and tick counter run
// S_FINISH | one cycle after the last step of an effect: note=0, done=1
module sfx_sequencer #(
    parameter int TICK_DIV = 1048576
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       enable_i,
    input  logic       ev_hit_i,
    input  logic       ev_wall_i,
    input  logic       ev_score_i,
    output logic [7:0] note_o,
    output logic       busy_o,
    output logic [1:0] active_fx_o,
    output logic       done_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PLAY   = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    localparam logic [23:0] PRESC_MAX = 24'(TICK_DIV - 1);

    function automatic logic [7:0] fx_note(input logic [1:0] fx, input logic [1:0] step);
        logic [7:0] n;
        case ({fx, step})
            4'b01_00: n = 8'd36;
            4'b10_00: n = 8'd24;
            4'b11_00: n = 8'd28;
            4'b11_01: n = 8'd32;
            4'b11_10: n = 8'd35;
            4'b11_11: n = 8'd40;
            default:  n = 8'd0;
        endcase
        return n;
    endfunction

    function automatic logic [3:0] fx_dur(input logic [1:0] fx, input logic [1:0] step);
        logic [3:0] d;
        case ({fx, step})
            4'b01_00: d = 4'd2;
            4'b10_00: d = 4'd3;
            4'b11_00: d = 4'd4;
            4'b11_01: d = 4'd4;
            4'b11_10: d = 4'd4;
            4'b11_11: d = 4'd8;
            default:  d = 4'd0;
        endcase
        return d;
    endfunction

    state_t      state_q, state_d;
    logic [1:0]  fx_q, fx_d;
    logic [1:0]  step_q, step_d;
    logic [3:0]  rem_q, rem_d;
    logic [23:0] presc_q, presc_d;
    logic [7:0]  note_q, note_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [1:0]  req_pri;
    logic        accept;
    logic        last_step;

    // Only the highest asserted event is considered; the rest are dropped.
    assign req_pri   = ev_score_i ? 2'd3 : (ev_wall_i ? 2'd2 : (ev_hit_i ? 2'd1 : 2'd0));
    assign accept    = enable_i && (req_pri != 2'd0) && ((state_q != S_PLAY) || (req_pri > fx_q));
    assign last_step = (fx_q == 2'd3) ? (step_q == 2'd3) : 1'b1;

    always_comb begin
        state_d = state_q;
        fx_d    = fx_q;
        step_d  = step_q;
        rem_d   = rem_q;
        presc_d = presc_q;
        done_d  = 1'b0;

        if (!enable_i) begin
            state_d = S_IDLE;
            fx_d    = 2'd0;
            step_d  = 2'd0;
            rem_d   = 4'd0;
            presc_d = 24'd0;
        end else if (accept) begin
            // Pre-emption restarts the prescaler so the first step runs full length.
            state_d = S_PLAY;
            fx_d    = req_pri;
            step_d  = 2'd0;
            rem_d   = fx_dur(req_pri, 2'd0);
            presc_d = 24'd0;
        end else begin
            case (state_q)
                S_PLAY: begin
                    if (presc_q == PRESC_MAX) begin
                        presc_d = 24'd0;
                        if (rem_q == 4'd1) begin
                            if (last_step) begin
                                state_d = S_FINISH;
                                fx_d    = 2'd0;
                                step_d  = 2'd0;
                                rem_d   = 4'd0;
                                done_d  = 1'b1;
                            end else begin
                                step_d = step_q + 2'd1;
                                rem_d  = fx_dur(fx_q, step_q + 2'd1);
                            end
                        end else begin
                            rem_d = rem_q - 4'd1;
                        end
                    end else begin
                        presc_d = presc_q + 24'd1;
                    end
                end
                S_FINISH: state_d = S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end

        busy_d = (state_d == S_PLAY);
        note_d = busy_d ? fx_note(fx_d, step_d) : 8'd0;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            fx_q    <= 2'd0;
            step_q  <= 2'd0;
            rem_q   <= 4'd0;
            presc_q <= 24'd0;
            note_q  <= 8'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            fx_q    <= fx_d;
            step_q  <= step_d;
            rem_q   <= rem_d;
            presc_q <= presc_d;
            note_q  <= note_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign note_o      = note_q;
    assign busy_o      = busy_q;
    assign active_fx_o = fx_q;
    assign done_o      = done_q;

endmodule
